// File: rtl/fx_alu_pkg.sv
// Shared definitions for the fx_alu_mc multi-cycle fixed-point ALU.
// Latency: n/a (opcodes, FSM state encoding and Q-format constant helpers only).
// Backpressure: n/a.
package fx_alu_pkg;

  // Opcodes, compared against the zero-extended instruction field.
  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_MUL  = 2;
  localparam int unsigned OP_MAC  = 3;
  localparam int unsigned OP_GELU = 4;
  localparam int unsigned OP_CLR  = 5;
  localparam int unsigned OP_MAX  = 6;
  localparam int unsigned OP_MIN  = 7;
  localparam int unsigned OP_RELU = 8;

  // EXEC doubles as GELU stage G0, so only G1..G7 need their own states.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_EXEC = 4'd1,
    ST_MAC2 = 4'd2,
    ST_G1   = 4'd3,
    ST_G2   = 4'd4,
    ST_G3   = 4'd5,
    ST_G4   = 4'd6,
    ST_G5   = 4'd7,
    ST_G6   = 4'd8,
    ST_G7   = 4'd9,
    ST_DONE = 4'd10
  } state_e;

  // GELU constants held as round(c * 2^20), rescaled to the target fraction width.
  localparam int GELU_C20 = 46887;   // 0.044715
  localparam int GELU_K20 = 836643;  // 0.7978846 (sqrt(2/pi))

  // Rescale a Q.20 constant to Q.frac_w, rounding half up when narrowing.
  function automatic int q_const(input int c20, input int frac_w);
    int r;
    if (frac_w >= 20) r = c20 <<< (frac_w - 20);
    else              r = (c20 + (1 <<< (19 - frac_w))) >>> (20 - frac_w);
    return r;
  endfunction

endpackage

// File: rtl/fx_mul_rnd_sat.sv
// Signed fixed-point multiply: full product, round at bit FRAC_W, shift, saturate.
// Latency: combinational. Backpressure: none.
// Ports: i_a, i_b signed Q operands; o_p saturated Q product.
module fx_mul_rnd_sat #(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 10,
  parameter int ROUND_MODE = 0
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_p
);

  localparam int PW = 2 * DATA_W;
  localparam logic signed [PW:0] P_MAX = {{(PW-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW:0] P_MIN = {{(PW-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PW-1:0] prod;
  logic signed [PW:0]   shifted;
  logic signed [PW:0]   rounded;
  logic                 round_up;

  always_comb begin
    prod    = i_a * i_b;
    // Floor shift; rounding is applied as a +1 correction from the dropped bits.
    shifted = $signed({prod[PW-1], prod}) >>> FRAC_W;
    if (ROUND_MODE == 0) begin
      round_up = prod[FRAC_W-1];
    end else begin
      // Exact half rounds only when the kept value is odd.
      round_up = prod[FRAC_W-1] & ((|prod[FRAC_W-2:0]) | shifted[0]);
    end
    rounded = shifted + $signed({{PW{1'b0}}, round_up});
    if (rounded > P_MAX)      o_p = P_MAX[DATA_W-1:0];
    else if (rounded < P_MIN) o_p = P_MIN[DATA_W-1:0];
    else                      o_p = rounded[DATA_W-1:0];
  end

endmodule

// File: rtl/fx_alu_mc.sv
// Multi-cycle saturating Q(INT_W).(FRAC_W) ALU with MAC accumulator and shared-multiplier GELU.
// Latency: 2 edges single-step/illegal, 3 MAC, 9 GELU (accept edge to edge sampling o_valid).
// Backpressure: o_busy high while not IDLE; i_valid during busy is dropped, not queued.
// Ports: i_clk, i_rst_n (async low); i_valid/i_inst/i_data_a/i_data_b command;
//        o_busy, o_valid (1-cycle), o_err (illegal opcode), o_data (held between results).
module fx_alu_mc
  import fx_alu_pkg::*;
#(
  parameter int INT_W      = 6,
  parameter int FRAC_W     = 10,
  parameter int INST_W     = 4,
  parameter int ROUND_MODE = 0,
  parameter int DATA_W     = INT_W + FRAC_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [INST_W-1:0] i_inst,
  input  logic [DATA_W-1:0] i_data_a,
  input  logic [DATA_W-1:0] i_data_b,
  output logic              o_busy,
  output logic              o_valid,
  output logic              o_err,
  output logic [DATA_W-1:0] o_data
);

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] Q_ONE   = DATA_W'(1 << FRAC_W);
  localparam logic signed [DATA_W-1:0] Q_HALF  = Q_ONE >>> 1;
  localparam logic signed [DATA_W-1:0] Q_QTR   = Q_ONE >>> 2;
  localparam logic signed [DATA_W-1:0] Q_1P5   = Q_ONE + Q_HALF;
  localparam logic signed [DATA_W-1:0] Q_M1    = -Q_ONE;
  localparam logic signed [DATA_W-1:0] Q_MHALF = -Q_HALF;
  localparam logic signed [DATA_W-1:0] Q_M1P5  = -Q_1P5;
  localparam logic signed [DATA_W-1:0] Q_C     = DATA_W'(q_const(GELU_C20, FRAC_W));
  localparam logic signed [DATA_W-1:0] Q_K     = DATA_W'(q_const(GELU_K20, FRAC_W));

  state_e                    state_q, state_d;
  logic [INST_W-1:0]         inst_q, inst_d;
  logic signed [DATA_W-1:0]  a_q, a_d, b_q, b_d, t_q, t_d, u_q, u_d;
  logic signed [DATA_W-1:0]  acc_q, acc_d, data_q, data_d;
  logic                      busy_q, busy_d, valid_q, valid_d, err_q, err_d;

  logic [31:0]               op;
  logic signed [DATA_W-1:0]  mul_a, mul_b, mul_y;
  logic signed [DATA_W-1:0]  add_a, add_b, add_y, tanh_y;
  logic                      add_sub, add_ovf;
  logic [DATA_W-1:0]         add_b_eff, add_sum;

  assign op = 32'(inst_q);

  fx_mul_rnd_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ROUND_MODE(ROUND_MODE)) u_mul (
    .i_a (mul_a),
    .i_b (mul_b),
    .o_p (mul_y)
  );

  // Operand steering for the one multiplier and one adder.
  always_comb begin
    mul_a   = a_q;
    mul_b   = b_q;
    add_a   = a_q;
    add_b   = b_q;
    add_sub = 1'b0;
    case (state_q)
      ST_EXEC: begin
        if (op == OP_GELU) mul_b = a_q;  // G0: x*x
        add_sub = (op == OP_SUB);
      end
      ST_MAC2: begin add_a = acc_q; add_b = t_q;   end
      ST_G1:   begin mul_a = t_q;   mul_b = Q_C;   end
      ST_G2:   begin add_a = t_q;   add_b = Q_ONE; end
      ST_G3:   begin mul_a = a_q;   mul_b = Q_K;   end
      ST_G4:   begin mul_a = t_q;   mul_b = u_q;   end
      ST_G6:   begin add_a = t_q;   add_b = Q_ONE; end
      ST_G7:   begin mul_a = t_q;   mul_b = a_q >>> 1; end
      default: ;
    endcase
  end

  // Saturating add/sub: subtract is a + ~b + 1; overflow when the addends share
  // a sign that the sum does not.
  always_comb begin
    add_b_eff = add_sub ? ~add_b : add_b;
    add_sum   = add_a + add_b_eff + {{(DATA_W-1){1'b0}}, add_sub};
    add_ovf   = (add_a[DATA_W-1] == add_b_eff[DATA_W-1]) && (add_sum[DATA_W-1] != add_a[DATA_W-1]);
    add_y     = add_ovf ? (add_a[DATA_W-1] ? SAT_MIN : SAT_MAX) : $signed(add_sum);
  end

  // Piecewise-linear tanh; halving is an arithmetic (floor) shift.
  always_comb begin
    if (t_q <= Q_M1P5)       tanh_y = Q_M1;
    else if (t_q <= Q_MHALF) tanh_y = (t_q >>> 1) - Q_QTR;
    else if (t_q <= Q_HALF)  tanh_y = t_q;
    else if (t_q <= Q_1P5)   tanh_y = (t_q >>> 1) + Q_QTR;
    else                     tanh_y = Q_ONE;
  end

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    a_d     = a_q;
    b_d     = b_q;
    t_d     = t_q;
    u_d     = u_q;
    acc_d   = acc_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          state_d = ST_EXEC;
          inst_d  = i_inst;
          a_d     = i_data_a;
          b_d     = i_data_b;
        end
      end
      ST_EXEC: begin
        state_d = ST_DONE;
        case (op)
          OP_ADD, OP_SUB: data_d = add_y;
          OP_MUL:         data_d = mul_y;
          OP_MAC:         begin t_d = mul_y; state_d = ST_MAC2; end
          OP_GELU:        begin t_d = mul_y; state_d = ST_G1;   end
          OP_CLR:         begin acc_d = '0; data_d = '0; end
          OP_MAX:         data_d = (a_q > b_q) ? a_q : b_q;
          OP_MIN:         data_d = (a_q < b_q) ? a_q : b_q;
          OP_RELU:        data_d = a_q[DATA_W-1] ? '0 : a_q;
          default:        err_d  = 1'b1;
        endcase
      end
      ST_MAC2: begin acc_d = add_y; data_d = add_y; state_d = ST_DONE; end
      ST_G1:   begin t_d = mul_y;  state_d = ST_G2;   end
      ST_G2:   begin u_d = add_y;  state_d = ST_G3;   end
      ST_G3:   begin t_d = mul_y;  state_d = ST_G4;   end
      ST_G4:   begin t_d = mul_y;  state_d = ST_G5;   end
      ST_G5:   begin t_d = tanh_y; state_d = ST_G6;   end
      ST_G6:   begin t_d = add_y;  state_d = ST_G7;   end
      ST_G7:   begin data_d = mul_y; state_d = ST_DONE; end
      default: state_d = ST_IDLE;
    endcase
    // Status flags are registered from the next state so they line up with it.
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      inst_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      u_q     <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
      u_q     <= u_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_fx_alu_mc.sv
// Scoreboard bench for fx_alu_mc: two instances (half-up and half-even rounding)
// share stimulus; a reference model pushes expected results, a monitor pops them.
module tb_fx_alu_mc;

  localparam longint SMAX = 32767;
  localparam longint SMIN = -32768;
  localparam longint ONE  = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [3:0]  i_inst;
  logic [15:0] i_a, i_b;
  logic        busy0, valid0, err0, busy1, valid1, err1;
  logic [15:0] data0, data1;

  always #5 clk = ~clk;

  fx_alu_mc #(.ROUND_MODE(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_inst(i_inst),
    .i_data_a(i_a), .i_data_b(i_b),
    .o_busy(busy0), .o_valid(valid0), .o_err(err0), .o_data(data0));

  fx_alu_mc #(.ROUND_MODE(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_inst(i_inst),
    .i_data_a(i_a), .i_data_b(i_b),
    .o_busy(busy1), .o_valid(valid1), .o_err(err1), .o_data(data1));

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    bit          err;
    int          lat;
    longint      t_acc;
  } exp_t;

  exp_t        sb[$];
  longint      acc_m[2];
  longint      data_m[2];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] held0, held1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic longint sat(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  function automatic longint fdiv(input longint n, input longint d);
    longint q = n / d;
    if ((n % d) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint mulq(input longint a, input longint b, input int mode);
    longint p = a * b;
    longint q = fdiv(p, ONE);
    longint r = p - q * ONE;
    if (r > ONE / 2 || (r == ONE / 2 && (mode == 0 || (q % 2) != 0))) q = q + 1;
    return sat(q);
  endfunction

  function automatic longint tanh_m(input longint x);
    if (x <= -1536) return -1024;
    if (x <= -512)  return fdiv(x, 2) - 256;
    if (x <= 512)   return x;
    if (x <= 1536)  return fdiv(x, 2) + 256;
    return 1024;
  endfunction

  function automatic longint gelu_m(input longint x, input int mode);
    longint t, u;
    t = mulq(x, x, mode);
    t = mulq(t, 46, mode);
    u = sat(t + ONE);
    t = mulq(x, 817, mode);
    t = mulq(t, u, mode);
    t = tanh_m(t);
    t = sat(t + ONE);
    return mulq(t, fdiv(x, 2), mode);
  endfunction

  task automatic model_issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             input longint t);
    exp_t   e;
    longint sa, sb_v, r;
    bit     wr;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    for (int m = 0; m < 2; m++) begin
      wr = 1'b1;
      r  = 0;
      case (op)
        4'd0: r = sat(sa + sb_v);
        4'd1: r = sat(sa - sb_v);
        4'd2: r = mulq(sa, sb_v, m);
        4'd3: begin acc_m[m] = sat(acc_m[m] + mulq(sa, sb_v, m)); r = acc_m[m]; end
        4'd4: r = gelu_m(sa, m);
        4'd5: begin acc_m[m] = 0; r = 0; end
        4'd6: r = (sa > sb_v) ? sa : sb_v;
        4'd7: r = (sa < sb_v) ? sa : sb_v;
        4'd8: r = (sa > 0) ? sa : 0;
        default: wr = 1'b0;
      endcase
      if (wr) data_m[m] = r;
    end
    e.d0    = 16'(data_m[0]);
    e.d1    = 16'(data_m[1]);
    e.err   = (op > 4'd8);
    e.lat   = (op == 4'd3) ? 3 : (op == 4'd4) ? 9 : 2;
    e.t_acc = t;
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      held0 = 16'h0;
      held1 = 16'h0;
    end else if (valid0 || valid1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: o_valid=%0b/%0b with nothing pending, expected 0 at t=%0t",
                 valid0, valid1, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("valid0", valid0, 1);
        chk("valid1", valid1, 1);
        chk("data_rm0", data0, e.d0);
        chk("data_rm1", data1, e.d1);
        chk("err0", err0, e.err);
        chk("err1", err1, e.err);
        chk("latency", (longint'($time) + 5 - e.t_acc) / 10, e.lat);
        held0 = e.d0;
        held1 = e.d1;
      end
    end else begin
      chk("hold0", data0, held0);
      chk("hold1", data1, held1);
      chk("err_idle", err0, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", busy0, 0);
  endtask

  // Issue one command; 'extra' holds i_valid high with garbage for that many
  // further edges while the block is busy (those must be ignored).
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int extra, input bit push);
    wait_idle();
    i_valid = 1'b1;
    i_inst  = op;
    i_a     = a;
    i_b     = b;
    @(posedge clk);
    if (push) model_issue(op, a, b, longint'($time));
    for (int k = 0; k < extra; k++) begin
      #1;
      i_inst = 4'($urandom);
      i_a    = 16'($urandom);
      i_b    = 16'($urandom);
      @(posedge clk);
    end
    #1;
    i_valid = 1'b0;
  endtask

  function automatic logic [15:0] rnd_opnd();
    logic [15:0] v;
    case ($urandom_range(0, 3))
      0:       v = 16'($urandom);
      1:       v = 16'($urandom_range(0, 4095));
      2:       v = 16'(-$urandom_range(0, 4095));
      default: v = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
    endcase
    return v;
  endfunction

  initial begin
    logic [3:0] op;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_inst  = 4'h0;
    i_a     = 16'h0;
    i_b     = 16'h0;
    acc_m   = '{0, 0};
    data_m  = '{0, 0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_data", data0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_err", err0, 0);

    // Directed cases
    issue(4'd0, 16'h7C00, 16'h0800, 0, 1);   // ADD saturates high
    issue(4'd1, 16'h8000, 16'h0400, 0, 1);   // SUB saturates low
    issue(4'd1, 16'h0000, 16'h8000, 0, 1);   // 0 - min saturates high
    issue(4'd2, 16'h0001, 16'h0200, 0, 1);   // exact half: 1 vs 0 by mode
    issue(4'd2, 16'h0003, 16'h0200, 0, 1);   // 1.5 LSB: both round to 2
    issue(4'd5, 16'h1234, 16'h5678, 0, 1);   // CLR
    issue(4'd3, 16'h0400, 16'h0800, 0, 1);   // MAC -> 2.0
    issue(4'd0, 16'h0100, 16'h0100, 0, 1);   // ADD leaves acc alone
    issue(4'd3, 16'h0600, 16'hFC00, 0, 1);   // MAC -> 0.5
    issue(4'd4, 16'h2000, 16'h0000, 0, 1);   // GELU(8)
    issue(4'd4, 16'hE000, 16'h0000, 0, 1);   // GELU(-8)
    issue(4'd4, 16'h0000, 16'h0000, 0, 1);   // GELU(0)
    issue(4'd4, 16'h0400, 16'h0000, 0, 1);   // GELU(1)
    issue(4'd4, 16'hFC00, 16'h0000, 0, 1);   // GELU(-1)
    issue(4'd15, 16'h7777, 16'h1111, 0, 1);  // illegal: err, data unchanged
    issue(4'd9, 16'h0001, 16'h0002, 2, 1);   // illegal plus ignored busy pulses
    issue(4'd6, 16'hFC00, 16'h0100, 0, 1);   // MAX
    issue(4'd7, 16'hFC00, 16'h0100, 0, 1);   // MIN
    issue(4'd8, 16'hFC00, 16'h0000, 0, 1);   // RELU negative
    issue(4'd8, 16'h0123, 16'h0000, 0, 1);   // RELU positive
    issue(4'd3, 16'h7FFF, 16'h7FFF, 1, 1);   // MAC saturates
    issue(4'd3, 16'h7FFF, 16'h7FFF, 2, 1);   // stays saturated

    // Reset in GELU stage G3: no result, everything back to zero
    issue(4'd4, 16'h1234, 16'h0000, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", valid0, 0);
    chk("rst_mid_busy", busy0, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    acc_m  = '{0, 0};
    data_m = '{0, 0};
    @(negedge clk);
    chk("post_rst_data", data0, 0);
    chk("post_rst_busy", busy0, 0);
    issue(4'd3, 16'h0400, 16'h0400, 0, 1);   // MAC from cleared acc -> 1.0

    // Randomised traffic
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(9, 15));
      else                           op = 4'($urandom_range(0, 8));
      issue(op, rnd_opnd(), rnd_opnd(), $urandom_range(0, 2), 1);
    end

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
